// File: rtl/pkt_tx_pkg.sv
// Shared definitions for the packet transmit generator.
// Holds the FSM state encoding, the NetFPGA-style module ctrl constants, the default widths
// and the fixed interface widths used by pkt_tx_gen and pkt_tx_buf.
// Optional feature macro: PKT_TX_GEN_IPG_EN adds the StGap state for inter-packet gaps.
package pkt_tx_pkg;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_CTRL_W = 8;
  localparam int unsigned DEF_DEPTH  = 256;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned GAP_W   = 8;
  localparam int unsigned COUNT_W = 16;

  // NetFPGA ctrl values: module header word and payload word
  localparam logic [7:0] CTRL_HDR     = 8'hFF;
  localparam logic [7:0] CTRL_PAYLOAD = 8'h00;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
`ifdef PKT_TX_GEN_IPG_EN
    StSend,
    StGap
`else
    StSend
`endif
  } state_e;

endpackage

// File: rtl/pkt_tx_buf.sv
// Packet word buffer: DEPTH words of WIDTH bits, one write port and one synchronous read port.
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write word address (addresses >= DEPTH are dropped)
//   wr_word  - write word
//   rd_addr  - read word address, captured every cycle
//   rd_word  - registered read data (zero for addresses >= DEPTH)
// Read-during-write to the same address returns the old contents.
module pkt_tx_buf
  import pkt_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_W + DEF_CTRL_W,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_word,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_word
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_in_range;
  logic             rd_in_range;

  assign wr_in_range = 32'(wr_addr) < DEPTH;
  assign rd_in_range = 32'(rd_addr) < DEPTH;

  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_addr[IdxW-1:0]] <= wr_word;
    end
    rd_word <= rd_in_range ? mem[rd_addr[IdxW-1:0]] : '0;
  end

endmodule

// File: rtl/pkt_tx_gen.sv
// Packet transmit generator: replays a preloaded buffer of (data, ctrl) words onto a
// NetFPGA-style packet bus with out_rdy back-pressure.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   ld_wr/addr/data/ctrl - buffer load port (honoured only while idle)
//   ld_len, start       - packet length in words and single-cycle transmit request
//   gap_cycles          - idle gap after each packet (only with PKT_TX_GEN_IPG_EN)
//   out_data/ctrl/wr    - registered output word and its valid strobe
//   out_rdy             - downstream accepts a word this cycle
//   busy, done          - not idle; one-cycle pulse after the last word
//   pkt_count           - completed packet counter (wraps)
// Optional feature macro: PKT_TX_GEN_IPG_EN.
module pkt_tx_gen
  import pkt_tx_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_wr,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0]  ld_data,
  input  logic [CTRL_W-1:0]  ld_ctrl,
  input  logic [LEN_W-1:0]   ld_len,
  input  logic               start,
`ifdef PKT_TX_GEN_IPG_EN
  input  logic [GAP_W-1:0]   gap_cycles,
`endif
  output logic [DATA_W-1:0]  out_data,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic               out_wr,
  input  logic               out_rdy,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] pkt_count
);

  localparam int unsigned WordW = DATA_W + CTRL_W;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [CTRL_W-1:0]  out_ctrl_q, out_ctrl_d;
  logic               out_wr_q, out_wr_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] pkt_count_q, pkt_count_d;
`ifdef PKT_TX_GEN_IPG_EN
  logic [GAP_W-1:0]   gap_len_q, gap_len_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
`endif

  logic               buf_wr_en;
  logic [WordW-1:0]   rd_word;

  // Buffer is frozen outside IDLE so a packet always replays what was loaded before start.
  assign buf_wr_en = ld_wr && (state_q == StIdle);

  // Reading at the next pointer keeps rd_word one word ahead while words are consumed.
  pkt_tx_buf #(
    .WIDTH (WordW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (ld_addr),
    .wr_word ({ld_data, ld_ctrl}),
    .rd_addr (ptr_d),
    .rd_word (rd_word)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    out_wr_d    = 1'b0;
    done_d      = 1'b0;
    pkt_count_d = pkt_count_q;
`ifdef PKT_TX_GEN_IPG_EN
    gap_len_d   = gap_len_q;
    gap_cnt_d   = gap_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (start && (ld_len != '0)) begin
          len_d   = ld_len;
          ptr_d   = '0;
          state_d = StFetch;
`ifdef PKT_TX_GEN_IPG_EN
          gap_len_d = gap_cycles;
`endif
        end
      end
      StFetch: begin
        state_d = StSend;
      end
      StSend: begin
        // ptr == len means the last word went out on the previous edge
        if (ptr_q == len_q) begin
          done_d      = 1'b1;
          pkt_count_d = pkt_count_q + 16'd1;
`ifdef PKT_TX_GEN_IPG_EN
          if (gap_len_q != '0) begin
            state_d   = StGap;
            gap_cnt_d = gap_len_q;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end else if (out_rdy) begin
          out_wr_d   = 1'b1;
          out_data_d = rd_word[WordW-1:CTRL_W];
          out_ctrl_d = rd_word[CTRL_W-1:0];
          ptr_d      = ptr_q + 8'd1;
        end
      end
`ifdef PKT_TX_GEN_IPG_EN
      StGap: begin
        gap_cnt_d = gap_cnt_q - 8'd1;
        if (gap_cnt_q == 8'd1) begin
          state_d = StIdle;
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      len_q       <= '0;
      out_data_q  <= '0;
      out_ctrl_q  <= '0;
      out_wr_q    <= 1'b0;
      done_q      <= 1'b0;
      pkt_count_q <= '0;
`ifdef PKT_TX_GEN_IPG_EN
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
      out_wr_q    <= out_wr_d;
      done_q      <= done_d;
      pkt_count_q <= pkt_count_d;
`ifdef PKT_TX_GEN_IPG_EN
      gap_len_q   <= gap_len_d;
      gap_cnt_q   <= gap_cnt_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_wr    = out_wr_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign pkt_count = pkt_count_q;

endmodule
